mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port word-addressed data memory (`mem`) between the multicycle CPU and a secondary requester (program loader / DMA). Sits between the requesters and `mem`; grants one owner at a time, routes that owner's address, write data and write enable to the memory, and returns registered read data. Burst-limited ownership bounds the wait of the non-owning port.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_pick.sv | 39 +++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : mem_arb_pkg                                                   |
// | Description: Shared constants for the two-port data-memory arbiter.        |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package mem_arb_pkg;

    localparam int ARB_AW = 16;
    localparam int ARB_DW = 16;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_OWN0 = 2'd1;
    localparam logic [1:0] ARB_OWN1 = 2'd2;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : mem_arb_pick                                                  |
// | Description: Combinational winner select for a fresh grant.                |
// |              MEM_ARB_RR_EN: ties go to the port that did not own last;     |
// |              otherwise port 0 wins every tie.                              |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic win_valid,
    output logic win_port
);

`ifndef MEM_ARB_RR_EN
    logic w_unused_last;
    assign w_unused_last = last_owner;
`endif

    always_comb begin
        win_valid = req0 | req1;
        win_port  = PORT_CPU;
        if (req0 && req1) begin
`ifdef MEM_ARB_RR_EN
            win_port = ~last_owner;
`else
            win_port = PORT_CPU;
`endif
        end else if (req1) begin
            win_port = PORT_AUX;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : mem_arbiter                                                   |
// | Description: Burst-limited two-port arbiter in front of the single-port    |
// |              data memory. Optional round-robin ties via MEM_ARB_RR_EN.     |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW        = ARB_AW,
    parameter int DW        = ARB_DW,
    parameter int MAX_BURST = 4
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] adr0,
    input  logic [AW-1:0] adr1,
    input  logic [DW-1:0] wd0,
    input  logic [DW-1:0] wd1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    localparam int                   c_burst_w   = $clog2(MAX_BURST + 1);
    localparam logic [c_burst_w-1:0] c_burst_max = c_burst_w'(MAX_BURST);
    localparam logic [c_burst_w-1:0] c_burst_lim = c_burst_w'(MAX_BURST - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic                 r_last;
    logic [c_burst_w-1:0] r_burst;
    logic                 r_rvalid0;
    logic                 r_rvalid1;
    logic [DW-1:0]        r_rdata0;
    logic [DW-1:0]        r_rdata1;
    logic                 w_xfer0;
    logic                 w_xfer1;
    logic                 w_xfer;
    logic                 w_limit;
    logic                 w_win_valid;
    logic                 w_win_port;
    logic                 w_we_raw;

    mem_arb_pick u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_owner (r_last),
        .win_valid  (w_win_valid),
        .win_port   (w_win_port)
    );

    assign gnt0    = (r_state == ARB_OWN0);
    assign gnt1    = (r_state == ARB_OWN1);
    assign w_xfer0 = gnt0 & req0;
    assign w_xfer1 = gnt1 & req1;
    assign w_xfer  = w_xfer0 | w_xfer1;
    // Limit counts the transfer happening this cycle, so the owner gets exactly MAX_BURST beats.
    assign w_limit = w_xfer && (r_burst >= c_burst_lim);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_win_valid)
                    w_state_nxt = (w_win_port == PORT_AUX) ? ARB_OWN1 : ARB_OWN0;
            end
            ARB_OWN0: begin
                if (!req0)
                    w_state_nxt = req1 ? ARB_OWN1 : ARB_IDLE;
                else if (w_limit && req1)
                    w_state_nxt = ARB_OWN1;
            end
            ARB_OWN1: begin
                if (!req1)
                    w_state_nxt = req0 ? ARB_OWN0 : ARB_IDLE;
                else if (w_limit && req0)
                    w_state_nxt = ARB_OWN0;
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_last  <= PORT_AUX;
            r_burst <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_burst <= '0;
                if (w_state_nxt == ARB_OWN0)
                    r_last <= PORT_CPU;
                else if (w_state_nxt == ARB_OWN1)
                    r_last <= PORT_AUX;
            end else if (w_xfer && (r_burst != c_burst_max)) begin
                r_burst <= r_burst + c_burst_w'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_xfer0 & ~we0;
            r_rvalid1 <= w_xfer1 & ~we1;
            if (w_xfer0 && !we0)
                r_rdata0 <= mem_rd;
            if (w_xfer1 && !we1)
                r_rdata1 <= mem_rd;
        end
    end

    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;

    always_comb begin
        mem_adr  = '0;
        mem_wd   = '0;
        w_we_raw = 1'b0;
        case (r_state)
            ARB_OWN0: begin
                mem_adr  = adr0;
                mem_wd   = wd0;
                w_we_raw = we0 & req0;
            end
            ARB_OWN1: begin
                mem_adr  = adr1;
                mem_wd   = wd1;
                w_we_raw = we1 & req1;
            end
            default: begin
                mem_adr  = '0;
                mem_wd   = '0;
                w_we_raw = 1'b0;
            end
        endcase
    end

    // Reset kills an in-flight write within the same cycle, before the edge.
    assign mem_we = w_we_raw & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_mem_arbiter                                                |
// | Description: Randomized and directed bench for mem_arbiter against an      |
// |              ownership/burst reference model and a shadow memory.          |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

    localparam int AW        = 16;
    localparam int DW        = 16;
    localparam int MAX_BURST = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] adr0, adr1;
    logic [DW-1:0] wd0, wd1;
    logic          gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [DW-1:0] rdata0, rdata1, mem_wd, mem_rd;
    logic [AW-1:0] mem_adr;

    logic [DW-1:0] mem    [0:255];
    logic [DW-1:0] shadow [0:255];

    int            n_cmp = 0;
    int            n_err = 0;

    int            m_own;
    int            m_cnt;
    int            m_last;
    logic          m_rv [2];
    logic [DW-1:0] m_rd [2];

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .adr0(adr0), .adr1(adr1), .wd0(wd0), .wd1(wd1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rdata0(rdata0), .rdata1(rdata1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    assign mem_rd = mem[mem_adr[8:1]];
    always @(posedge clk) if (mem_we) mem[mem_adr[8:1]] <= mem_wd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own  = -1;
        m_cnt  = 0;
        m_last = 1;
        for (int p = 0; p < 2; p++) begin
            m_rv[p] = 1'b0;
            m_rd[p] = '0;
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req0 = r0; we0 = w0; adr0 = a0; wd0 = d0;
        req1 = r1; we1 = w1; adr1 = a1; wd1 = d1;
    endtask

    // Compare outputs against the model mid-cycle, after inputs have settled.
    task automatic settle();
        logic          e_we;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_wd;
        #3;
        e_we  = (m_own == 0) ? (req0 & we0) : (m_own == 1) ? (req1 & we1) : 1'b0;
        e_adr = (m_own == 0) ? adr0 : (m_own == 1) ? adr1 : '0;
        e_wd  = (m_own == 0) ? wd0  : (m_own == 1) ? wd1  : '0;
        check("gnt0", gnt0, m_own == 0);
        check("gnt1", gnt1, m_own == 1);
        check("mem_we", mem_we, e_we);
        check("mem_adr", mem_adr, e_adr);
        check("mem_wd", mem_wd, e_wd);
        check("rvalid0", rvalid0, m_rv[0]);
        check("rvalid1", rvalid1, m_rv[1]);
        if (m_rv[0]) check("rdata0", rdata0, m_rd[0]);
        if (m_rv[1]) check("rdata1", rdata1, m_rd[1]);
    endtask

    // Apply this cycle's transfer to the model, pick the next owner, step the clock.
    task automatic advance();
        logic          r [2];
        logic          w [2];
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        int            nxt, cnt_after, o;
        bit            xfer;
        r[0] = req0; w[0] = we0; a[0] = adr0; d[0] = wd0;
        r[1] = req1; w[1] = we1; a[1] = adr1; d[1] = wd1;
        m_rv[0] = 1'b0;
        m_rv[1] = 1'b0;
        xfer = (m_own >= 0) && r[m_own];
        if (xfer) begin
            if (w[m_own]) begin
                shadow[a[m_own][8:1]] = d[m_own];
            end else begin
                m_rv[m_own] = 1'b1;
                m_rd[m_own] = shadow[a[m_own][8:1]];
            end
        end
        cnt_after = 0;
        if (m_own < 0) begin
            if (r[0] && r[1]) nxt = RR ? 1 - m_last : 0;
            else if (r[0])    nxt = 0;
            else if (r[1])    nxt = 1;
            else              nxt = -1;
        end else begin
            o = m_own;
            cnt_after = xfer ? ((m_cnt + 1 > MAX_BURST) ? MAX_BURST : m_cnt + 1) : m_cnt;
            if (!r[o])                                   nxt = r[1-o] ? 1 - o : -1;
            else if (cnt_after >= MAX_BURST && r[1-o])   nxt = 1 - o;
            else                                         nxt = o;
        end
        if (nxt != m_own) begin
            m_cnt = 0;
            if (nxt >= 0) m_last = nxt;
        end else begin
            m_cnt = cnt_after;
        end
        m_own = nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic exp_tie;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 16'(i * 7 + 3);
            shadow[i] = 16'(i * 7 + 3);
        end
        reset = 1'b1;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check("rst_gnt0", gnt0, 1'b0);
        check("rst_gnt1", gnt1, 1'b0);
        check("rst_rvalid0", rvalid0, 1'b0);
        check("rst_rvalid1", rvalid1, 1'b0);
        check("rst_rdata0", rdata0, 16'h0000);
        check("rst_rdata1", rdata1, 16'h0000);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_adr", mem_adr, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single port write then read back.
        drive(1, 1, 16'h0004, 16'hBEEF, 0, 0, '0, '0);
        settle(); check("sp_gnt0_lat", gnt0, 1'b0); advance();
        settle(); check("sp_gnt0", gnt0, 1'b1); check("sp_we", mem_we, 1'b1); advance();
        we0 = 1'b0;
        cycle();
        req0 = 1'b0;
        settle(); check("sp_rvalid0", rvalid0, 1'b1); check("sp_rdata0", rdata0, 16'hBEEF); advance();
        cycle();

        // Tie from IDLE after reset, then burst alternation and release.
        do_reset();
        drive(1, 0, 16'h0020, '0, 1, 0, 16'h0040, '0);
        cycle();
        for (int i = 0; i < 22; i++) begin
            settle();
            check($sformatf("burst_g0_%0d", i), gnt0, ((i / 4) % 2) == 0);
            check($sformatf("burst_g1_%0d", i), gnt1, ((i / 4) % 2) == 1);
            advance();
        end
        req1 = 1'b0;
        settle(); check("rel_own1", gnt1, 1'b1); advance();
        req1 = 1'b1;
        for (int j = 0; j < 5; j++) begin
            settle();
            check($sformatf("rel_g0_%0d", j), gnt0, j < 4);
            advance();
        end

        // Tie resolution after port 0 has owned and released.
        do_reset();
        drive(1, 0, 16'h0008, '0, 0, 0, '0, '0);
        cycle();
        cycle();
        req0 = 1'b0;
        cycle();
        drive(1, 0, 16'h0008, '0, 1, 0, 16'h000A, '0);
        cycle();
        exp_tie = RR;
        settle(); check("cfg_tie_gnt1", gnt1, exp_tie); check("cfg_tie_gnt0", gnt0, !exp_tie); advance();

        // Reset asserted in the middle of an OWN1 write.
        do_reset();
        drive(0, 0, '0, '0, 1, 1, 16'h0010, 16'h1234);
        cycle();
        settle(); check("rw_gnt1_pre", gnt1, 1'b1); check("rw_we_pre", mem_we, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check("rw_gnt1", gnt1, 1'b0);
        check("rw_mem_we", mem_we, 1'b0);
        check("rw_rvalid0", rvalid0, 1'b0);
        check("rw_rvalid1", rvalid1, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        check("rw_mem_word", mem[8], shadow[8]);
        reset = 1'b0;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        cycle();

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 16'($urandom_range(0, 511)), 16'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 16'($urandom_range(0, 511)), 16'($urandom));
            cycle();
        end
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        cycle();
        cycle();
        for (int i = 0; i < 256; i++)
            if (mem[i] !== shadow[i]) check($sformatf("mem_word_%0d", i), mem[i], shadow[i]);
        check("mem_word_last", mem[255], shadow[255]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
